// File: rtl/data_sram_slave_pkg.sv
// Shared definitions for the data-SRAM responder: the handshake FSM encoding,
// the wait-counter sizing and the byte-lane count.
package data_sram_slave_pkg;

  localparam int LAT_MAX = 4;
  localparam int CNT_W   = $clog2(LAT_MAX);
  localparam int LANES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_sram_slave_sram_bank.sv
// Word-wide storage array with per-byte-lane write mask and a registered
// read port that can also be forced to zero for non-load responses.
module sram_bank
  import data_sram_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [LANES-1:0]  wr_mask,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [31:0]       rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q, rd_data_d;

  // NOTE: the array has no reset; clearing it would forbid block-RAM mapping,
  // and its contents are allowed to survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        // NOTE: sequential state is always updated with <=, so every flop
        // samples pre-edge values regardless of block ordering.
        if (wr_mask[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: the default hold assignment comes first so no path leaves
    // rd_data_d unassigned, which would infer a latch.
    rd_data_d = rd_data_q;
    if (rd_clr)     rd_data_d = '0;
    else if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_sram_slave.sv
// Data-SRAM responder: one-outstanding-request handshake with LATENCY wait
// states, address-window check and byte-lane stores into sram_bank.
module data_sram_slave
  import data_sram_slave_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_load_q, is_load_d;
  logic               hit_q, hit_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               data_ok_q, data_ok_d;
  logic               err_q, err_d;

  logic               req_hit, req_load, accept, enter_resp;
  logic [ADDR_W-1:0]  req_idx, cur_idx;
  logic               cur_load, cur_hit;
  logic               rd_en, rd_clr, wr_en;
  logic               unused_addr_lsb;

  assign req_hit  = (data_sram_addr[31:ADDR_W+2] == '0);
  assign req_idx  = data_sram_addr[ADDR_W+1:2];
  assign req_load = (data_sram_wen == 4'b0000);
  // Byte offset is checked by the initiator.
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign data_sram_addr_ok = (state_q != ST_WAIT);
  assign accept            = data_sram_en & data_sram_addr_ok;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    hit_d     = hit_q;
    idx_d     = idx_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      default: begin
        // IDLE and RESP share the acceptance rules (back-to-back in RESP).
        state_d = ST_IDLE;
        if (data_sram_en) begin
          is_load_d = req_load;
          hit_d     = req_hit;
          idx_d     = req_idx;
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
    endcase
  end

  // With LATENCY=1 the read happens on the accepting edge, so the live
  // request fields are used instead of the not-yet-latched copies.
  assign cur_load   = accept ? req_load : is_load_q;
  assign cur_hit    = accept ? req_hit  : hit_q;
  assign cur_idx    = accept ? req_idx  : idx_q;
  assign enter_resp = (state_d == ST_RESP);

  assign rd_en  = enter_resp & cur_load & cur_hit;
  assign rd_clr = enter_resp & ~(cur_load & cur_hit);
  assign wr_en  = accept & req_hit & ~req_load;

  assign data_ok_d = enter_resp;
  assign err_d     = enter_resp & ~cur_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
    end
  end

  sram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_mask (data_sram_wen),
    .wr_idx  (req_idx),
    .wr_data (data_sram_wdata),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_idx  (cur_idx),
    .rd_data (data_sram_rdata)
  );

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_err     = err_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: three instances (LATENCY 1, 3, 4) checked every
// cycle against a transaction-level model, plus directed literal scenarios.
module tb_data_sram_slave;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  resetn;
  logic [N-1:0]          en;
  logic [N-1:0][3:0]     wen;
  logic [N-1:0][31:0]    addr, wdata, rdata;
  logic [N-1:0]          aok, dok, errv;

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_sram_slave #(
      .ADDR_W  (12),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .data_sram_en      (en[g]),
      .data_sram_wen     (wen[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_addr_ok (aok[g]),
      .data_sram_data_ok (dok[g]),
      .data_sram_rdata   (rdata[g]),
      .data_sram_err     (errv[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit [31:0] m_mem   [N][4096];
  bit [3:0]  m_known [N][4096];
  bit        pend    [N];
  int        resp_cyc[N];
  bit [31:0] exp_rd  [N];
  bit [3:0]  exp_rmask[N];
  bit        exp_err [N];
  int        cyc = 0;
  bit        e_aok, e_dok;

  task automatic model_accept(input int k);
    bit        hit;
    bit [11:0] idx;
    hit         = (addr[k][31:14] == 18'd0);
    idx         = addr[k][13:2];
    pend[k]     = 1'b1;
    resp_cyc[k] = cyc + lat_of(k);
    exp_err[k]  = !hit;
    if (wen[k] != 4'b0000) begin
      if (hit) begin
        for (int i = 0; i < 4; i++) begin
          if (wen[k][i]) begin
            m_mem[k][idx][8*i +: 8] = wdata[k][8*i +: 8];
            m_known[k][idx][i]      = 1'b1;
          end
        end
      end
      exp_rd[k]    = 32'h0;
      exp_rmask[k] = hit ? 4'hF : 4'h0;
    end else begin
      exp_rd[k]    = hit ? m_mem[k][idx] : 32'h0;
      exp_rmask[k] = hit ? m_known[k][idx] : 4'hF;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!resetn) begin
        check($sformatf("u%0d reset addr_ok", k), 32'(aok[k]), 32'd1);
        check($sformatf("u%0d reset data_ok", k), 32'(dok[k]), 32'd0);
        check($sformatf("u%0d reset rdata", k), rdata[k], 32'h0);
        check($sformatf("u%0d reset err", k), 32'(errv[k]), 32'd0);
        pend[k] = 1'b0;
      end else begin
        e_dok = pend[k] && (cyc == resp_cyc[k]);
        e_aok = !pend[k] || (cyc >= resp_cyc[k]);
        check($sformatf("u%0d addr_ok", k), 32'(aok[k]), 32'(e_aok));
        check($sformatf("u%0d data_ok", k), 32'(dok[k]), 32'(e_dok));
        if (e_dok) begin
          check($sformatf("u%0d err", k), 32'(errv[k]), 32'(exp_err[k]));
          if (exp_rmask[k] != 4'h0)
            check($sformatf("u%0d rdata", k), rdata[k] & lane_bits(exp_rmask[k]),
                  exp_rd[k] & lane_bits(exp_rmask[k]));
          pend[k] = 1'b0;
        end
        if (en[k] && e_aok) model_accept(k);
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  // Present a request and hold it until accepted; returns just after the
  // accepting edge with en dropped.
  task automatic drive(input int k, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, output int waited);
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    waited = 0;
    @(negedge clk);
    while (!aok[k] && waited < 20) begin
      waited++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (!aok[k]) check($sformatf("u%0d accept timeout", k), 32'(aok[k]), 32'd1);
    @(posedge clk); #1;
    en[k] = 1'b0;
  endtask

  task automatic wait_resp(input int k, output logic [31:0] rd, output logic er, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dok[k] && n < 12);
    check($sformatf("u%0d response seen", k), 32'(dok[k]), 32'd1);
    rd = rdata[k];
    er = errv[k];
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int k, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er, output int n);
    int waited;
    drive(k, w, a, d, waited);
    wait_resp(k, rd, er, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n, waited;
    logic [3:0]  w;
    logic [31:0] a;

    resetn = 1'b1;
    en = '0; wen = '0; addr = '0; wdata = '0;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Full-word store then load, LATENCY=1.
    xfer(0, 4'hF, 32'h100, 32'hDEADBEEF, rd, er, n);
    check("store err", 32'(er), 32'd0);
    check("store latency", 32'(n), 32'd1);
    xfer(0, 4'h0, 32'h100, 32'h0, rd, er, n);
    check("load word", rd, 32'hDEADBEEF);
    check("load err", 32'(er), 32'd0);
    check("load latency", 32'(n), 32'd1);

    // Byte and halfword lane merges.
    xfer(0, 4'b0100, 32'h100, 32'h55555555, rd, er, n);
    xfer(0, 4'h0, 32'h100, 32'h0, rd, er, n);
    check("byte lane merge", rd, 32'hDE55BEEF);
    xfer(0, 4'b0011, 32'h100, 32'h12341234, rd, er, n);
    xfer(0, 4'h0, 32'h100, 32'h0, rd, er, n);
    check("half lane merge", rd, 32'hDE551234);

    // Out-of-window accesses.
    xfer(0, 4'hF, 32'h0, 32'hA5A50000, rd, er, n);
    xfer(0, 4'h0, 32'h0001_0000, 32'h0, rd, er, n);
    check("miss load rdata", rd, 32'h0);
    check("miss load err", 32'(er), 32'd1);
    xfer(0, 4'hF, 32'h0001_0000, 32'hFFFFFFFF, rd, er, n);
    check("miss store err", 32'(er), 32'd1);
    xfer(0, 4'h0, 32'h0, 32'h0, rd, er, n);
    check("index 0 intact", rd, 32'hA5A50000);
    check("index 0 err", 32'(er), 32'd0);

    // Back-to-back store/load at LATENCY=1.
    drive(0, 4'hF, 32'h200, 32'hCAFEF00D, waited);
    en[0] = 1'b1; wen[0] = 4'h0; addr[0] = 32'h200;
    @(negedge clk);
    check("b2b first data_ok", 32'(dok[0]), 32'd1);
    check("b2b addr_ok", 32'(aok[0]), 32'd1);
    @(posedge clk); #1;
    en[0] = 1'b0;
    @(negedge clk);
    check("b2b second data_ok", 32'(dok[0]), 32'd1);
    check("b2b load data", rdata[0], 32'hCAFEF00D);
    @(posedge clk); #1;

    // LATENCY=3 stall window and held second request.
    xfer(1, 4'hF, 32'h100, 32'h13579BDF, rd, er, n);
    check("lat3 store latency", 32'(n), 32'd3);
    xfer(1, 4'hF, 32'h104, 32'h2468ACE0, rd, er, n);
    drive(1, 4'h0, 32'h100, 32'h0, waited);
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'h104;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check($sformatf("lat3 T+%0d addr_ok", i), 32'(aok[1]), 32'd0);
      check($sformatf("lat3 T+%0d data_ok", i), 32'(dok[1]), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("lat3 T+3 addr_ok", 32'(aok[1]), 32'd1);
    check("lat3 T+3 data_ok", 32'(dok[1]), 32'd1);
    check("lat3 T+3 rdata", rdata[1], 32'h13579BDF);
    @(posedge clk); #1;
    en[1] = 1'b0;
    wait_resp(1, rd, er, n);
    check("lat3 held req latency", 32'(n), 32'd3);
    check("lat3 held req data", rd, 32'h2468ACE0);

    // Reset during WAIT at LATENCY=4.
    xfer(2, 4'hF, 32'h300, 32'h0BADC0DE, rd, er, n);
    check("lat4 store latency", 32'(n), 32'd4);
    check("lat4 store rdata", rd, 32'h0);
    drive(2, 4'h0, 32'h300, 32'h0, waited);
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("lat4 dropped data_ok", 32'(dok[2]), 32'd0);
      check("lat4 addr_ok after reset", 32'(aok[2]), 32'd1);
    end
    @(posedge clk); #1;
    xfer(2, 4'h0, 32'h300, 32'h0, rd, er, n);
    check("lat4 store survives reset", rd, 32'h0BADC0DE);
    check("lat4 load latency", 32'(n), 32'd4);

    // Randomized traffic, checked by the model every cycle.
    for (int k = 0; k < N; k++) begin
      for (int op = 0; op < 200; op++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        case ($urandom_range(0, 9))
          0, 1, 2, 3: w = 4'h0;
          4, 5, 6:    w = 4'hF;
          default:    w = 4'($urandom_range(1, 15));
        endcase
        case ($urandom_range(0, 19))
          0:       a = (32'($urandom_range(1, 16'hFFFF)) << 16) | 32'($urandom_range(0, 3));
          1:       a = 32'h0000_4000 | 32'($urandom_range(0, 3));
          2:       a = 32'h0000_3FFC | 32'($urandom_range(0, 3));
          default: a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        endcase
        drive(k, w, a, $urandom, waited);
      end
      repeat (6) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_slave.md
# data_sram_slave

Responder end of the data-SRAM interface driven by the CPU memory stage: it accepts byte-enabled load/store requests on `data_sram_*`, commits stores into an internal word array with per-lane masking, and returns load data after a configurable number of wait states. It replaces the ideal zero-latency RAM in simulation and FPGA builds, so that pipeline stall logic is exercised against a realistic one-outstanding-request handshake.

## Interface
- `ADDR_W`, 12: word-index width; array holds 2^ADDR_W 32-bit words (16 KiB at default).
- `LATENCY`, 1: cycles from request acceptance to response; legal range 1..4.
- `clk`  in  1  single clock; all state changes on rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `data_sram_en`  in  1  request valid.
- `data_sram_wen`  in  4  byte-lane write enables, already shifted to lane position; 4'b0000 = load.
- `data_sram_addr`  in  32  physical byte address; kseg translation is done by the initiator.
- `data_sram_wdata`  in  32  store data, already replicated across lanes.
- `data_sram_addr_ok`  out  1  request accepted this cycle when high together with `data_sram_en`.
- `data_sram_data_ok`  out  1  one-cycle response pulse for loads and stores.
- `data_sram_rdata`  out  32  load data; valid only while `data_sram_data_ok`=1.
- `data_sram_err`  out  1  out-of-window access flag; valid only while `data_sram_data_ok`=1.

## Operation
- States: IDLE, WAIT, RESP. One request outstanding at most.
- IDLE: `addr_ok`=1. On `en`=1, latch `wen`/index/hit, load wait counter with LATENCY-1, go to RESP if LATENCY=1, else WAIT.
- WAIT: `addr_ok`=0; counter decrements each cycle; go to RESP on the edge where it reaches 0.
- RESP: `data_ok`=1, `rdata`/`err` driven from registers. `addr_ok`=1, so a new request in this cycle is accepted (back-to-back); its next state follows the IDLE rules. Otherwise return to IDLE.
- Window: hit when `addr[31:ADDR_W+2]`==0; index = `addr[ADDR_W+1:2]`; `addr[1:0]` ignored (alignment exceptions are raised upstream).
- Store, hit: each lane i with `wen[i]`=1 writes `wdata[8i+7:8i]` at the accepting edge; other lanes are kept. Response carries `rdata`=0, `err`=0.
- Store, miss: no array write; response carries `err`=1.
- Load, hit: array word sampled on the edge entering RESP; no sign extension or shifting (done by the initiator).
- Load, miss: `rdata`=32'h0, `err`=1.
- `wen` values other than 0000/0001/0011/1111 shifted patterns are still honoured lane by lane; there is no legality check.
- Requests with `en`=0 are ignored; when `addr_ok`=0, inputs are don't-care.

## Timing
- Reset (async assert): state IDLE, counter 0, `addr_ok`=1, `data_ok`=0, `rdata`=0, `err`=0. Array contents are not cleared.
- Reset mid-WAIT/RESP: pending response dropped with no `data_ok`. A store already committed at acceptance stays in the array.
- Request accepted in cycle T → `data_ok` in cycle T+LATENCY, for exactly one cycle.
- Throughput: one request per LATENCY cycles; with LATENCY=1, one per cycle.
- Store accepted at T followed by a load of the same word accepted at T+1: the load returns the new data. The write commits at the end of T; the read samples at the end of T+LATENCY.
- Outputs are registered except `addr_ok`, which decodes directly from the state.

## Structure
- Shared package: state encoding (IDLE/WAIT/RESP), `LAT_MAX`=4, counter width `$clog2(LAT_MAX)`, lane count 4.
- Sub-module `sram_bank`: 2^ADDR_W × 32 array with a 4-bit lane write mask and a registered read port; the FSM, counter and window check live in the top level.

## Test plan
- Reset, then store `wen`=1111 `addr`=0x100 `wdata`=0xDEADBEEF; load 0x100 → `data_ok` at T+1, `rdata`=0xDEADBEEF, `err`=0.
- Byte store `wen`=0100 `wdata`=0x55555555 to 0x100, then load → `rdata`=0xDE55BEEF; halfword `wen`=0011 `wdata`=0x12341234 → 0xDE551234.
- LATENCY=3: load accepted at T → `addr_ok`=0 during T+1..T+2, `data_ok` only at T+3; a second request held during T+1..T+2 is accepted at T+3.
- Load 0x0001_0000 (outside the default window) → `rdata`=0, `err`=1; a miss store there leaves word index 0 unchanged.
- Back-to-back at LATENCY=1: store then load of the same address in consecutive cycles → the load returns the stored value, with `data_ok` high for 2 consecutive cycles.
- Assert `resetn`=0 during WAIT (LATENCY=4) → no `data_ok`; after release, `addr_ok`=1 and a previously committed store reads back intact.
